seq_pattern_gen: RTL and testbench
==================================

# seq_pattern_gen

Serial bit-stream generator that drives the single-bit input of the sequence-detector FSMs. It captures a parallel pattern and emits it MSB-first, one bit per clock, a programmable number of times. A programmable idle gap separates repetitions. It is the transmit end of the detector's `x` line and is used both in the FPGA demo top and as a synthesizable stimulus source for detector benches.

## Interface
- `PAT_W`, default 4: pattern length in bits, ≥2.
- `GAP_W`, default 4: width of the gap-length field.
- `REP_W`, default 8: width of the repetition-count field.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous, active-low (0 = reset).
- `start` input 1: request; sampled only in IDLE.
- `pattern` input `PAT_W`: bit pattern, captured on accepted `start`.
- `repeat_cnt` input `REP_W`: number of pattern repetitions, captured on accepted `start`.
- `gap` input `GAP_W`: filler cycles between repetitions, captured on accepted `start`.
- `x` output 1: registered serial bit to the detector.
- `valid` output 1: high while `x` carries a pattern bit.
- `frame` output 1: high on the first (MSB) bit of each repetition.
- `busy` output 1: high from the cycle after start acceptance through the last emitted bit.
- `done` output 1: one-cycle pulse after the last bit of the last repetition.

## Operation
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - `start`=1 captures `pattern`, `repeat_cnt` and `gap`.
  - If `repeat_cnt`==0, go to DONE. Otherwise go to SEND with bit index = `PAT_W`-1 and repetition counter = `repeat_cnt`.
- SEND:
  - `x` = `pattern_q[idx]`, `valid`=1, `frame`=1 when idx==`PAT_W`-1. idx decrements each cycle.
  - At idx==0, decrement the repetition counter.
  - If the remaining count is 0, go to DONE.
  - Else if `gap_q`==0, go to SEND with idx reloaded. This gives back-to-back patterns, which exercises detector overlap.
  - Else go to GAP with the gap counter = `gap_q`.
- GAP:
  - `x` = filler bit (0 by default), `valid`=0.
  - The counter decrements; on reaching 1, go to SEND with idx reloaded.
- DONE:
  - `done`=1, `busy`=0, `x`=0, `valid`=0.
  - Go to IDLE next cycle.
- `start` in any state other than IDLE is ignored. It is not queued.
- Captured fields are held stable for the whole run. Input changes during a run have no effect.
- Counters are unsigned. No wrap occurs because every counter stops at its terminal value.

## Timing
- All outputs are registered. Reset values: `x`=0, `valid`=0, `frame`=0, `busy`=0, `done`=0, state=IDLE.
- Latency: `start` sampled high at edge k puts the MSB on `x` (with `valid`, `frame`, `busy` high) after edge k+1.
- Each bit is held exactly one cycle.
- Busy duration is R·`PAT_W` + (R−1)·G cycles, where R = repeat count and G = gap.
- `done` pulses in the cycle immediately after the last bit.
- `repeat_cnt`==0: `done` pulses in the cycle after acceptance, `busy` never asserts, no bits are emitted.
- No gap follows the final repetition.
- `start` held high continuously: a new run is accepted in the IDLE cycle after DONE. There is exactly one `x`=0 idle cycle plus the DONE cycle between runs.
- Reset asserted mid-run: all outputs drop to reset values asynchronously. After release, the block stays in IDLE until a fresh `start`.

## Configuration
- `SEQ_GEN_LFSR_FILL_EN` defined:
  - GAP cycles drive `x` from an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset).
  - The LFSR advances only in GAP cycles.
  - This stresses false-match rejection in the detector.
- Not defined: the filler is constant 0 and no LFSR logic is synthesized.
- `valid` behaviour is identical in both builds.

## Structure
- Shared package `seq_pkg`:
  - FSM state enum (IDLE/SEND/GAP/DONE).
  - Default `PAT_W`.
  - Default detector pattern constant 4'b1101.
  - LFSR seed and tap constants.
- Sub-module `seq_lfsr8` (8-bit LFSR with advance enable) holds the filler source. It is instantiated only under `SEQ_GEN_LFSR_FILL_EN`.

## Test plan
- Reset: `rst`=0 during random inputs → all outputs 0. After release with `start`=0, outputs stay 0 for 10 cycles.
- Single run: pattern=4'b1101, repeat=1, gap=0 → `x` = 1,1,0,1 on cycles k+1..k+4. `frame` high only on k+1. `done` at k+5. `busy` high for 4 cycles.
- Back-to-back: pattern=4'b1101, repeat=3, gap=0 → 12 consecutive bits 110111011101 with `valid` continuously high. `frame` at bits 0, 4, 8. Detector output z pulses 3 times (overlap case).
- Gapped: pattern=4'b1010, repeat=2, gap=3 → 1010,000,1010. `busy` lasts 11 cycles. `valid` low during the 3 gap cycles.
- Edge/abort:
  - repeat=0 → `done` pulse only, `busy` stays 0.
  - `start` pulsed mid-run → ignored.
  - `rst` asserted at bit 2 of repeat=5 → immediate zero outputs, no `done`.
- LFSR build (`SEQ_GEN_LFSR_FILL_EN`): repeat=2, gap=8 → gap bits match the reference LFSR sequence from seed 8'hA5. Pattern bits are unchanged.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator: FSM states, default
// widths, the reference detector pattern and the filler LFSR constants.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    localparam int         SEQ_PAT_W       = 4;
    localparam logic [3:0] SEQ_DET_PATTERN = 4'b1101;

    // Fibonacci taps 8,6,5,4 map to bits 7,5,4,3 of the shift register.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/seq_lfsr8.sv
// 8-bit Fibonacci LFSR that steps only when adv_i is high; the MSB is the
// pseudo-random filler bit used between pattern repetitions.
module seq_lfsr8
    import seq_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic adv_i,
    output logic bit_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next-state: hold unless advancing.
    always_comb begin
        if (adv_i) begin
            lfsr_d = lfsr8_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Shift register with seed on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[7];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: emits a captured pattern MSB-first, repeated with
// an idle gap between repetitions. Define SEQ_GEN_LFSR_FILL_EN for LFSR gap fill.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = SEQ_PAT_W,
    parameter int GAP_W = 4,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap,
    output logic             x,
    output logic             valid,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

    seq_state_e       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             x_q, x_d;
    logic             valid_q, valid_d;
    logic             frame_q, frame_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             filler_s;

`ifdef SEQ_GEN_LFSR_FILL_EN
    logic lfsr_adv_s;
    assign lfsr_adv_s = (state_q == ST_GAP);

    seq_lfsr8 u_lfsr (
        .clk_i  (clk),
        .rst_ni (rst),
        .adv_i  (lfsr_adv_s),
        .bit_o  (filler_s)
    );
`else
    assign filler_s = 1'b0;
`endif

    // Next-state and next-output logic; outputs are registered one cycle
    // behind the state that produces them.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        idx_d   = idx_q;
        x_d     = 1'b0;
        valid_d = 1'b0;
        frame_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pat_d = pattern;
                    rep_d = repeat_cnt;
                    gap_d = gap;
                    idx_d = IDX_MAX;
                    if (repeat_cnt == REP_W'(0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                x_d     = pat_q[idx_q];
                valid_d = 1'b1;
                busy_d  = 1'b1;
                frame_d = (idx_q == IDX_MAX);
                if (idx_q == IDX_W'(0)) begin
                    rep_d = rep_q - REP_W'(1);
                    idx_d = IDX_MAX;
                    if (rep_q == REP_W'(1)) begin
                        state_d = ST_DONE;
                    end else if (gap_q == GAP_W'(0)) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_GAP;
                        gcnt_d  = gap_q;
                    end
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            ST_GAP: begin
                x_d    = filler_s;
                busy_d = 1'b1;
                if (gcnt_q == GAP_W'(1)) begin
                    state_d = ST_SEND;
                    idx_d   = IDX_MAX;
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, captured fields, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            idx_q   <= '0;
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x     = x_q;
    assign valid = valid_q;
    assign frame = frame_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: table of runs with hand-computed
// serial streams, plus start-held, mid-run start and reset-abort sequences.
module tb_seq_pattern_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] pattern;
    logic [7:0] repeat_cnt;
    logic [3:0] gap;
    logic       x, valid, frame, busy, done;

    int total = 0;
    int bad   = 0;
    logic [7:0] lfsr_m;

    seq_pattern_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .gap        (gap),
        .x          (x),
        .valid      (valid),
        .frame      (frame),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pat;
        logic [7:0]  rep;
        logic [3:0]  gp;
        int          len;
        logic [31:0] ex;
        logic [31:0] ev;
        logic [31:0] ef;
        bit          mid_start;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {x, valid, frame, busy, done};
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic [4:0] e;
        logic       xb;
        @(negedge clk);
        pattern = v.pat; repeat_cnt = v.rep; gap = v.gp; start = 1'b1;
        @(negedge clk);
        start = 1'b0; pattern = ~v.pat; repeat_cnt = 8'd7; gap = 4'd2;
        chk({tag, "_accept"}, {27'd0, outs()}, 32'd0);
        for (int c = 0; c < v.len; c++) begin
            @(negedge clk);
            xb = v.ex[v.len-1-c];
`ifdef SEQ_GEN_LFSR_FILL_EN
            if (!v.ev[v.len-1-c]) begin
                xb = lfsr_m[7];
                lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
            end
`endif
            e = {xb, v.ev[v.len-1-c], v.ef[v.len-1-c], 1'b1, 1'b0};
            chk($sformatf("%s_c%0d", tag, c), {27'd0, outs()}, {27'd0, e});
            start = (v.mid_start && c == 4);
            pattern = 4'b0000; repeat_cnt = 8'd1; gap = 4'd0;
        end
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_done"}, {27'd0, outs()}, 32'd1);
        @(negedge clk);
        chk({tag, "_after"}, {27'd0, outs()}, 32'd0);
    endtask

    logic [4:0] held_exp[12];

    initial begin
        vecs[0] = '{4'b1101, 8'd1, 4'd0, 4,  32'b1101, 32'b1111, 32'b1000, 1'b0};
        vecs[1] = '{4'b1101, 8'd3, 4'd0, 12, 32'b110111011101, 32'hFFF, 32'b100010001000, 1'b1};
        vecs[2] = '{4'b1010, 8'd2, 4'd3, 11, 32'b1010_000_1010, 32'b1111_000_1111, 32'b1000_000_1000, 1'b0};
        vecs[3] = '{4'b0110, 8'd1, 4'd5, 4,  32'b0110, 32'b1111, 32'b1000, 1'b0};
        vecs[4] = '{4'b0001, 8'd2, 4'd1, 9,  32'b0001_0_0001, 32'b1111_0_1111, 32'b1000_0_1000, 1'b0};
        vecs[5] = '{4'b1100, 8'd2, 4'd8, 16, 32'b1100_00000000_1100, 32'b1111_00000000_1111, 32'b1000_00000000_1000, 1'b0};
        vecs[6] = '{4'b1111, 8'd0, 4'd4, 0,  32'd0, 32'd0, 32'd0, 1'b0};

        held_exp = '{5'b11110, 5'b11010, 5'b01010, 5'b11010, 5'b00001, 5'b00000,
                     5'b11110, 5'b11010, 5'b01010, 5'b11010, 5'b00001, 5'b00000};

        // Reset with random inputs toggling.
        rst = 1'b0; start = 1'b0; pattern = 4'd0; repeat_cnt = 8'd0; gap = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            pattern = 4'($urandom); repeat_cnt = 8'($urandom); gap = 4'($urandom);
            chk($sformatf("reset_%0d", i), {27'd0, outs()}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle_%0d", i), {27'd0, outs()}, 32'd0);
        end
        lfsr_m = 8'hA5;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Start held high: back-to-back runs separated by done + one idle cycle.
        @(negedge clk);
        pattern = 4'b1101; repeat_cnt = 8'd1; gap = 4'd0; start = 1'b1;
        @(negedge clk);
        chk("held_accept", {27'd0, outs()}, 32'd0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("held_c%0d", c), {27'd0, outs()}, {27'd0, held_exp[c]});
            if (c == 5) start = 1'b0;
        end

        // Reset during bit 2 of a five-repetition run.
        @(negedge clk);
        pattern = 4'b1101; repeat_cnt = 8'd5; gap = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_b1", {27'd0, outs()}, {27'd0, 5'b11110});
        @(negedge clk);
        chk("abort_b2", {27'd0, outs()}, {27'd0, 5'b11010});
        #2 rst = 1'b0;
        #1 chk("abort_async", {27'd0, outs()}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort_hold_%0d", i), {27'd0, outs()}, 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("abort_idle_%0d", i), {27'd0, outs()}, 32'd0);
        end
        lfsr_m = 8'hA5;
        run_vec(vecs[2], "recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
